// File: rtl/mac_pkg.sv
// Shared types for the MAC result serializer: FSM states, frame layout and widths.
// The CHK state exists only when MAC_SER_CHECKSUM_EN is defined.
package mac_pkg;

    localparam int TAG_W  = 4;
    localparam int DROP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYTE0,
        ST_BYTE1,
`ifdef MAC_SER_CHECKSUM_EN
        ST_BYTE2,
        ST_CHK
`else
        ST_BYTE2
`endif
    } state_t;

    typedef struct packed {
        logic [15:0]      result;
        logic             overflow;
        logic [TAG_W-1:0] tag;
    } frame_t;

    localparam int FRAME_W = $bits(frame_t);

`ifdef MAC_SER_CHECKSUM_EN
    localparam state_t LAST_ST = ST_CHK;
`else
    localparam state_t LAST_ST = ST_BYTE2;
`endif

    function automatic logic [7:0] status_byte(frame_t f);
        return {f.overflow, 3'b000, f.tag};
    endfunction

endpackage

// File: rtl/mac_frame_fifo.sv
// Synchronous frame FIFO with registered full/empty flags. Besides the head it exposes
// the frame that becomes head after a pop, so the serializer can chain frames without a bubble.
module mac_frame_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [FRAME_W-1:0] push_data,
    input  logic               pop,
    output logic [FRAME_W-1:0] head,
    output logic [FRAME_W-1:0] next_head,
    output logic               next_valid,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW:0]        count_reg;
    logic [AW:0]        count_next;
    logic               full_reg;
    logic               empty_reg;
    logic               wr_en;
    logic               rd_en;

    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
    assign wr_en = push && (!full_reg || pop);
    assign rd_en = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en)
            count_next = count_reg + 1'b1;
        else if (!wr_en && rd_en)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == (AW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign head       = mem[rd_ptr_reg];
    // With a single stored frame, the successor can only be the one being pushed now.
    assign next_head  = (count_reg > (AW+1)'(1)) ? mem[rd_ptr_reg + 1'b1] : push_data;
    assign next_valid = (count_reg > (AW+1)'(1)) || wr_en;
    assign full       = full_reg;
    assign empty      = empty_reg;

endmodule

// File: rtl/mac_result_serializer.sv
// Buffers tagged MAC results and sends each as a byte frame over a valid/ready stream.
// Define MAC_SER_CHECKSUM_EN to append an XOR checksum byte (4-byte frames).
module mac_result_serializer
    import mac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_strobe,
    input  logic [15:0] cap_result,
    input  logic        cap_overflow,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt
);

    state_t            state_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DROP_W-1:0] drop_reg;
    logic [7:0]        tx_data_reg;
    logic              tx_valid_reg;
    logic              tx_last_reg;

    frame_t push_frame;
    frame_t head;
    frame_t next_head;
    logic   next_valid;
    logic   full;
    logic   empty;
    logic   last_hs;
    logic   accept;
    logic   drop;

    assign push_frame = '{result: cap_result, overflow: cap_overflow, tag: tag_reg};
    // tx_valid is high in every non-idle state, so the last-state handshake only needs tx_ready.
    assign last_hs    = (state_reg == LAST_ST) && tx_ready;
    assign accept     = cap_strobe && (!full || last_hs);
    assign drop       = cap_strobe && full && !last_hs;

    mac_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (cap_strobe),
        .push_data  (push_frame),
        .pop        (last_hs),
        .head       (head),
        .next_head  (next_head),
        .next_valid (next_valid),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg  <= '0;
            drop_reg <= '0;
        end else begin
            if (accept)
                tag_reg <= tag_reg + 1'b1;
            if (drop && drop_reg != '1)
                drop_reg <= drop_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (!empty) begin
                    state_reg    <= ST_BYTE0;
                    tx_data_reg  <= head.result[7:0];
                    tx_valid_reg <= 1'b1;
                    tx_last_reg  <= 1'b0;
                end
                ST_BYTE0: if (tx_ready) begin
                    state_reg   <= ST_BYTE1;
                    tx_data_reg <= head.result[15:8];
                end
                ST_BYTE1: if (tx_ready) begin
                    state_reg   <= ST_BYTE2;
                    tx_data_reg <= status_byte(head);
                    tx_last_reg <= (LAST_ST == ST_BYTE2);
                end
`ifdef MAC_SER_CHECKSUM_EN
                ST_BYTE2: if (tx_ready) begin
                    state_reg   <= ST_CHK;
                    tx_data_reg <= head.result[7:0] ^ head.result[15:8] ^ status_byte(head);
                    tx_last_reg <= 1'b1;
                end
                ST_CHK: if (tx_ready) begin
`else
                ST_BYTE2: if (tx_ready) begin
`endif
                    if (next_valid) begin
                        state_reg   <= ST_BYTE0;
                        tx_data_reg <= next_head.result[7:0];
                        tx_last_reg <= 1'b0;
                    end else begin
                        state_reg    <= ST_IDLE;
                        tx_valid_reg <= 1'b0;
                        tx_last_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                    tx_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_last   = tx_last_reg;
    assign fifo_full = full;
    assign drop_cnt  = drop_reg;

endmodule
